// File: rtl/pcie_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// pcie_tx_arbiter_pkg
// Shared types and constants for the PCIe TX completion-stream arbiter.
//   - TX beat layout (last/strob/data), identical to the DMA response FIFO word
//   - arbiter FSM state encoding
//   - arbiter register bundle and its reset value
//   - round-robin pointer advance helper
// Ports: none (package).
// ---------------------------------------------------------------------------
package pcie_tx_arbiter_pkg;

  localparam int RESP_FIFO_WIDTH    = 73;
  localparam int PCIE_TX_BEAT_WIDTH = RESP_FIFO_WIDTH;
  localparam int TX_DATA_W          = 64;
  localparam int TX_STROB_W         = 8;

  // Register bundle is sized for the largest supported requester count so the
  // same typedef serves every NREQ; unused upper grant/pointer bits stay zero.
  localparam int ARB_MAX_NREQ = 8;
  localparam int ARB_PTR_W    = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  last;
    logic [TX_STROB_W-1:0] strob;
    logic [TX_DATA_W-1:0]  data;
  } pcie_tx_beat_t;

  typedef struct packed {
    arb_state_e              state;
    logic [ARB_PTR_W-1:0]    rr_ptr;
    logic [ARB_MAX_NREQ-1:0] grant;
    logic                    tx_valid;
    logic [TX_DATA_W-1:0]    tx_data;
    logic [TX_STROB_W-1:0]   tx_strob;
    logic                    tx_last;
  } pcie_tx_arbiter_registers;

  localparam pcie_tx_arbiter_registers PCIE_TX_ARBITER_REGISTERS_RESET = '{
    state:    ARB_IDLE,
    rr_ptr:   '0,
    grant:    '0,
    tx_valid: 1'b0,
    tx_data:  '0,
    tx_strob: '0,
    tx_last:  1'b0
  };

  // Pointer to the requester after idx, wrapping at nreq.
  function automatic logic [ARB_PTR_W-1:0] rr_next(input logic [ARB_PTR_W-1:0] idx,
                                                   input int nreq);
    if (int'(idx) >= nreq - 1) begin
      return '0;
    end
    return idx + ARB_PTR_W'(1);
  endfunction

endpackage

// File: rtl/pcie_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// pcie_tx_arbiter_if
// Bundles the requester-side and endpoint-side handshake signals of the
// PCIe TX arbiter.
//   i_req_valid/data/strob/last : NREQ packed requester beats (requester k at
//                                 slice k of each vector)
//   o_req_ready                 : per-requester accept, one-hot or zero
//   o_tx_valid/data/strob/last  : registered output beat
//   i_tx_ready                  : endpoint accepts the output beat
//   o_grant, o_busy             : current owner and activity status
// Modports: slave = arbiter side, master = requester/endpoint side.
// ---------------------------------------------------------------------------
interface pcie_tx_arbiter_if
  import pcie_tx_arbiter_pkg::*;
#(
  parameter int NREQ = 2
);

  logic [NREQ-1:0]            i_req_valid;
  logic [NREQ*TX_DATA_W-1:0]  i_req_data;
  logic [NREQ*TX_STROB_W-1:0] i_req_strob;
  logic [NREQ-1:0]            i_req_last;
  logic [NREQ-1:0]            o_req_ready;
  logic                       o_tx_valid;
  logic [TX_DATA_W-1:0]       o_tx_data;
  logic [TX_STROB_W-1:0]      o_tx_strob;
  logic                       o_tx_last;
  logic                       i_tx_ready;
  logic [NREQ-1:0]            o_grant;
  logic                       o_busy;

  modport slave (
    input  i_req_valid, i_req_data, i_req_strob, i_req_last, i_tx_ready,
    output o_req_ready, o_tx_valid, o_tx_data, o_tx_strob, o_tx_last,
           o_grant, o_busy
  );

  modport master (
    output i_req_valid, i_req_data, i_req_strob, i_req_last, i_tx_ready,
    input  o_req_ready, o_tx_valid, o_tx_data, o_tx_strob, o_tx_last,
           o_grant, o_busy
  );

endinterface

// File: rtl/pcie_tx_arbiter_rr_select.sv
// ---------------------------------------------------------------------------
// pcie_tx_arbiter_rr_select
// Combinational round-robin selector: returns a one-hot grant for the first
// asserted valid bit at or after ptr, wrapping modulo NREQ. Zero when no
// valid bit is set.
//   valid : NREQ request vector
//   ptr   : starting index (must be < NREQ)
//   grant : one-hot selection or zero
// ---------------------------------------------------------------------------
module pcie_tx_arbiter_rr_select
  import pcie_tx_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]      valid,
  input  logic [ARB_PTR_W-1:0] ptr,
  output logic [NREQ-1:0]      grant
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDX_W'((int'(ptr) + i) % NREQ);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// ---------------------------------------------------------------------------
// pcie_tx_arbiter
// Packet-atomic round-robin arbiter sharing one 64-bit PCIe TX completion
// stream between NREQ TLP sources. Ownership is taken in an arbitration cycle,
// held from the first beat until the last beat is accepted, then priority
// rotates to the requester after the owner. A single registered output stage
// drives the endpoint.
//   i_clk, i_nrst : clock, asynchronous active-low reset
//   bus (slave)   : requester beats/ready, output beat/ready, grant, busy
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ARB_IDLE | no owner; pick next requester from rr_ptr, accept nothing
//   ARB_LOCK | grant held; owner's beats accepted whenever the slot frees
// ---------------------------------------------------------------------------
module pcie_tx_arbiter
  import pcie_tx_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  pcie_tx_arbiter_if.slave  bus
);

  pcie_tx_arbiter_registers r;
  pcie_tx_arbiter_registers r_nxt;

  logic                          slot_free;
  logic                          accept;
  logic [NREQ-1:0]               grant_cur;
  logic [NREQ-1:0]               sel_grant;
  logic [NREQ-1:0]               ready;
  logic [ARB_PTR_W-1:0]          grant_idx;
  logic [PCIE_TX_BEAT_WIDTH-1:0] sel_flat;
  pcie_tx_beat_t                 sel_beat;

  assign grant_cur = r.grant[NREQ-1:0];

  // Ready depends only on registered state and i_tx_ready, never on the
  // requester inputs, so requesters can safely make valid depend on ready.
  assign slot_free = !r.tx_valid || bus.i_tx_ready;
  assign ready     = (r.state == ARB_LOCK && slot_free) ? grant_cur : '0;
  assign accept    = |(ready & bus.i_req_valid);

  // Grant is one-hot, so an AND-OR mux selects the owner's beat.
  always_comb begin
    sel_flat = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_cur[k]) begin
        sel_flat = sel_flat | {bus.i_req_last[k],
                               bus.i_req_strob[TX_STROB_W*k +: TX_STROB_W],
                               bus.i_req_data[TX_DATA_W*k +: TX_DATA_W]};
      end
    end
  end

  assign sel_beat = pcie_tx_beat_t'(sel_flat);

  always_comb begin
    grant_idx = '0;
    for (int k = 0; k < ARB_MAX_NREQ; k++) begin
      if (r.grant[k]) begin
        grant_idx = ARB_PTR_W'(k);
      end
    end
  end

  pcie_tx_arbiter_rr_select #(
    .NREQ (NREQ)
  ) u_rr_select (
    .valid (bus.i_req_valid),
    .ptr   (r.rr_ptr),
    .grant (sel_grant)
  );

  always_comb begin
    r_nxt = r;

    // Output stage: load on accept, otherwise drain when the endpoint takes
    // the beat. Payload is held after drain, only valid drops.
    if (accept) begin
      r_nxt.tx_valid = 1'b1;
      r_nxt.tx_data  = sel_beat.data;
      r_nxt.tx_strob = sel_beat.strob;
      r_nxt.tx_last  = sel_beat.last;
    end else if (slot_free) begin
      r_nxt.tx_valid = 1'b0;
    end

    case (r.state)
      ARB_IDLE: begin
        if (|bus.i_req_valid) begin
          r_nxt.state                = ARB_LOCK;
          r_nxt.grant                = '0;
          r_nxt.grant[NREQ-1:0]      = sel_grant;
        end
      end
      ARB_LOCK: begin
        // A requester dropping valid mid-packet just stalls here; ownership
        // is only released by an accepted last beat.
        if (accept && sel_beat.last) begin
          r_nxt.state  = ARB_IDLE;
          r_nxt.grant  = '0;
          r_nxt.rr_ptr = rr_next(grant_idx, NREQ);
        end
      end
      default: begin
        r_nxt = PCIE_TX_ARBITER_REGISTERS_RESET;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r <= PCIE_TX_ARBITER_REGISTERS_RESET;
    end else begin
      r <= r_nxt;
    end
  end

  assign bus.o_req_ready = ready;
  assign bus.o_grant     = grant_cur;
  assign bus.o_tx_valid  = r.tx_valid;
  assign bus.o_tx_data   = r.tx_data;
  assign bus.o_tx_strob  = r.tx_strob;
  assign bus.o_tx_last   = r.tx_last;
  assign bus.o_busy      = (r.state == ARB_LOCK) || r.tx_valid;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pcie_tx_arbiter
// Bench for pcie_tx_arbiter with NREQ=2. Requesters are modelled as beat
// queues; a behavioural model tracks owner, rotation pointer and the output
// slot as plain integers and predicts every visible output each cycle.
// ---------------------------------------------------------------------------
module tb_pcie_tx_arbiter;

  localparam int NREQ = 2;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic nrst;

  always #5 clk = ~clk;

  pcie_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  pcie_tx_arbiter #(.NREQ(NREQ)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  beat_t src_q[NREQ][$];
  bit    hold[NREQ];

  // behavioural model
  bit          m_lock;
  int          m_own;
  int          m_ptr;
  bit          m_txv;
  logic [63:0] m_txd;
  logic [7:0]  m_txs;
  bit          m_txl;

  bit          rand_mode = 1'b0;
  bit          in_pkt    = 1'b0;
  logic [7:0]  pkt_tag   = '0;
  int          out_cnt   = 0;
  int          pushed_cnt = 0;
  int          order_q[$];
  logic [1:0]  prev_grant = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 1'b0;
    m_own  = 0;
    m_ptr  = 0;
    m_txv  = 1'b0;
    m_txd  = '0;
    m_txs  = '0;
    m_txl  = 1'b0;
  endtask

  task automatic push_beat(input int k, input logic [63:0] dd, input logic [7:0] ss, input bit ll);
    beat_t b;
    b.d = dd;
    b.s = ss;
    b.l = ll;
    src_q[k].push_back(b);
    pushed_cnt++;
  endtask

  task automatic push_pkt(input int k, input int len, input logic [63:0] base);
    for (int i = 0; i < len; i++) begin
      push_beat(k, base + 64'(i), 8'hFF, (i == len - 1));
    end
  endtask

  // One clock: drive inputs at negedge, check outputs against the model,
  // then advance the model to what the next rising edge should produce.
  task automatic cyc(input bit txr);
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] l;
    logic [63:0]     d[NREQ];
    logic [7:0]      s[NREQ];
    logic [1:0]      er;
    logic [1:0]      eg;
    bit              free;
    bit              acc;
    bit              picked;
    int              c;

    @(negedge clk);
    for (int k = 0; k < NREQ; k++) begin
      if (src_q[k].size() > 0 && !hold[k]) begin
        v[k] = 1'b1;
        d[k] = src_q[k][0].d;
        s[k] = src_q[k][0].s;
        l[k] = src_q[k][0].l;
      end else begin
        v[k] = 1'b0;
        d[k] = {$urandom, $urandom};
        s[k] = 8'($urandom);
        l[k] = 1'($urandom);
      end
    end
    bus.i_req_valid = v;
    bus.i_req_last  = l;
    bus.i_req_data  = {d[1], d[0]};
    bus.i_req_strob = {s[1], s[0]};
    bus.i_tx_ready  = txr;
    #1;

    free = !m_txv || txr;
    er   = (m_lock && free) ? (2'b01 << m_own) : 2'b00;
    eg   = m_lock ? (2'b01 << m_own) : 2'b00;
    chk("req_ready", bus.o_req_ready, er);
    chk("grant", bus.o_grant, eg);
    chk("tx_valid", bus.o_tx_valid, m_txv);
    chk("tx_data", bus.o_tx_data, m_txd);
    chk("tx_strob", bus.o_tx_strob, m_txs);
    chk("tx_last", bus.o_tx_last, m_txl);
    chk("busy", bus.o_busy, m_lock || m_txv);

    if (bus.o_tx_valid && txr) begin
      out_cnt++;
      if (rand_mode) begin
        if (in_pkt) chk("atomic_tag", bus.o_tx_data[63:56], pkt_tag);
        else pkt_tag = bus.o_tx_data[63:56];
        in_pkt = !bus.o_tx_last;
      end
    end
    if (bus.o_grant != 2'b00 && prev_grant == 2'b00) begin
      order_q.push_back(bus.o_grant[1] ? 1 : 0);
    end
    prev_grant = bus.o_grant;

    acc = m_lock && free && v[m_own];
    if (acc) begin
      m_txv = 1'b1;
      m_txd = d[m_own];
      m_txs = s[m_own];
      m_txl = l[m_own];
      void'(src_q[m_own].pop_front());
    end else if (free) begin
      m_txv = 1'b0;
    end
    if (!m_lock) begin
      picked = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        c = (m_ptr + i) % NREQ;
        if (!picked && v[c]) begin
          m_own  = c;
          picked = 1'b1;
        end
      end
      m_lock = picked;
    end else if (acc && l[m_own]) begin
      m_lock = 1'b0;
      m_ptr  = (m_own + 1) % NREQ;
    end
  endtask

  task automatic drain(input string tag, input int max_cyc);
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (src_q[0].size() == 0 && src_q[1].size() == 0 && !m_lock && !m_txv) break;
      cyc(1'b1);
    end
    chk(tag, 64'(src_q[0].size() + src_q[1].size() + int'(m_lock) + int'(m_txv)), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] snap_d;
    logic [7:0]  snap_s;
    logic        snap_l;

    nrst            = 1'b0;
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    bus.i_req_strob = '0;
    bus.i_req_last  = '0;
    bus.i_tx_ready  = 1'b0;
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tx_valid", bus.o_tx_valid, 0);
    chk("rst_grant", bus.o_grant, 0);
    chk("rst_ready", bus.o_req_ready, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_data", bus.o_tx_data, 0);
    chk("rst_strob", bus.o_tx_strob, 0);
    chk("rst_last", bus.o_tx_last, 0);
    @(negedge clk);
    nrst = 1'b1;

    // both requesters valid together after reset: req0 first, gap, then req1
    push_pkt(0, 2, 64'hA000_0000_0000_0000);
    push_pkt(1, 2, 64'hB000_0000_0000_0000);
    cyc(1'b1);
    cyc(1'b1);
    chk("t2_grant_first", bus.o_grant, 2'b01);
    cyc(1'b1);
    cyc(1'b1);
    chk("t2_gap_grant", bus.o_grant, 2'b00);
    chk("t2_gap_ready", bus.o_req_ready, 2'b00);
    cyc(1'b1);
    chk("t2_grant_second", bus.o_grant, 2'b10);
    drain("t2_drain", 20);

    // req0 back-to-back packets, req1 pending: strict alternation
    order_q.delete();
    push_pkt(0, 2, 64'h0100_0000_0000_0000);
    push_pkt(0, 1, 64'h0200_0000_0000_0000);
    push_pkt(0, 2, 64'h0300_0000_0000_0000);
    push_pkt(1, 1, 64'h1100_0000_0000_0000);
    push_pkt(1, 2, 64'h1200_0000_0000_0000);
    drain("t3_drain", 60);
    chk("t3_npkts", 64'(order_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < order_q.size(); i++) begin
      chk("t3_order", 64'(order_q[i]), 64'(i % 2));
    end

    // single requester 3-beat TLP latency and last marking
    push_beat(0, 64'h1111_1111_1111_1111, 8'hFF, 1'b0);
    push_beat(0, 64'h2222_2222_2222_2222, 8'hFF, 1'b0);
    push_beat(0, 64'h3333_3333_3333_3333, 8'hFF, 1'b1);
    cyc(1'b1);
    chk("t1_idle_grant", bus.o_grant, 2'b00);
    chk("t1_idle_valid", bus.o_tx_valid, 0);
    cyc(1'b1);
    chk("t1_grant", bus.o_grant, 2'b01);
    chk("t1_ready", bus.o_req_ready, 2'b01);
    chk("t1_n1_valid", bus.o_tx_valid, 0);
    cyc(1'b1);
    chk("t1_b0_data", bus.o_tx_data, 64'h1111_1111_1111_1111);
    chk("t1_b0_last", bus.o_tx_last, 0);
    cyc(1'b1);
    chk("t1_b1_data", bus.o_tx_data, 64'h2222_2222_2222_2222);
    cyc(1'b1);
    chk("t1_b2_data", bus.o_tx_data, 64'h3333_3333_3333_3333);
    chk("t1_b2_last", bus.o_tx_last, 1);
    chk("t1_b2_grant", bus.o_grant, 2'b00);
    cyc(1'b1);
    chk("t1_done_valid", bus.o_tx_valid, 0);
    chk("t1_held_data", bus.o_tx_data, 64'h3333_3333_3333_3333);
    chk("t1_done_busy", bus.o_busy, 0);

    // endpoint backpressure for 5 cycles mid-packet
    push_pkt(0, 4, 64'hC0DE_0000_0000_0000);
    repeat (3) cyc(1'b1);
    cyc(1'b0);
    snap_d = bus.o_tx_data;
    snap_s = bus.o_tx_strob;
    snap_l = bus.o_tx_last;
    chk("t4_hold_beat", snap_d, 64'hC0DE_0000_0000_0001);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0);
      chk("t4_bp_data", bus.o_tx_data, snap_d);
      chk("t4_bp_strob", bus.o_tx_strob, snap_s);
      chk("t4_bp_last", bus.o_tx_last, snap_l);
      chk("t4_bp_ready", bus.o_req_ready, 2'b00);
    end
    drain("t4_drain", 20);
    chk("t4_beats", 64'(out_cnt), 64'(pushed_cnt));

    // owner drops valid mid-packet while the other requester waits
    push_pkt(0, 4, 64'hD000_0000_0000_0000);
    cyc(1'b1);
    push_pkt(1, 2, 64'hE000_0000_0000_0000);
    cyc(1'b1);
    hold[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      chk("t5_grant", bus.o_grant, 2'b01);
      chk("t5_rdy1", bus.o_req_ready[1], 0);
    end
    hold[0] = 1'b0;
    for (int i = 0; i < 10 && src_q[0].size() > 0; i++) begin
      cyc(1'b1);
      chk("t5_rdy1_run", bus.o_req_ready[1], 0);
    end
    drain("t5_drain", 20);

    // reset in the middle of a 4-beat packet, pointer previously at 1
    push_pkt(0, 1, 64'hF100_0000_0000_0000);
    drain("t6_pre_drain", 10);
    push_pkt(0, 4, 64'hF000_0000_0000_0000);
    repeat (3) cyc(1'b1);
    @(negedge clk);
    nrst = 1'b0;
    bus.i_req_valid = '0;
    #1;
    chk("t6_rst_valid", bus.o_tx_valid, 0);
    chk("t6_rst_grant", bus.o_grant, 2'b00);
    chk("t6_rst_busy", bus.o_busy, 0);
    chk("t6_rst_ready", bus.o_req_ready, 2'b00);
    src_q[0].delete();
    src_q[1].delete();
    model_reset();
    out_cnt    = 0;
    pushed_cnt = 0;
    prev_grant = 2'b00;
    @(negedge clk);
    nrst = 1'b1;
    push_pkt(0, 2, 64'h6000_0000_0000_0000);
    push_pkt(1, 2, 64'h7000_0000_0000_0000);
    cyc(1'b1);
    cyc(1'b1);
    chk("t6_post_grant", bus.o_grant, 2'b01);
    drain("t6_drain", 20);

    // randomized traffic against the model
    rand_mode = 1'b1;
    in_pkt    = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (src_q[k].size() < 3 && $urandom_range(0, 3) == 0) begin
          int len;
          len = int'($urandom_range(1, 5));
          for (int b = 0; b < len; b++) begin
            push_beat(k, {8'(k), 24'($urandom), 32'($urandom)},
                      ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                      (b == len - 1));
          end
        end
        hold[k] = ($urandom_range(0, 4) == 0);
      end
      cyc($urandom_range(0, 3) != 0);
    end
    drain("rand_drain", 300);
    chk("rand_beats", 64'(out_cnt), 64'(pushed_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcie_tx_arbiter.md
# pcie_tx_arbiter

Packet-atomic round-robin arbiter that shares the single 64-bit PCIe TX completion stream between several TLP sources (DMA completion engine, MSI/message generator, config responder). Each requester presents beats in the same last/strob/data format as the DMA response FIFO (73 bits). The arbiter locks onto one requester from its first beat until its last beat is accepted, then rotates priority. A registered output stage feeds the PCIe endpoint TX interface.

## Interface
- NREQ, 2: number of requesters, 1..8
- i_clk  in  1  system clock; all logic on rising edge
- i_nrst  in  1  reset, asynchronous, active-low
- i_req_valid  in  NREQ  beat valid per requester
- i_req_data  in  NREQ*64  beat data; requester k at [64k+63:64k]
- i_req_strob  in  NREQ*8  byte enables; requester k at [8k+7:8k]
- i_req_last  in  NREQ  final beat of TLP
- o_req_ready  out  NREQ  beat accepted when valid&ready; one-hot or zero
- o_tx_valid  out  1  output beat valid
- o_tx_data  out  64  output data
- o_tx_strob  out  8  output byte enables
- o_tx_last  out  1  output final beat
- i_tx_ready  in  1  endpoint accepts beat
- o_grant  out  NREQ  one-hot current owner; zero when idle
- o_busy  out  1  packet in progress or output stage occupied

## Operation
- States: ARB_IDLE, ARB_LOCK.
- ARB_IDLE: if any i_req_valid, pick first valid index at or after rr_ptr (wrap modulo NREQ); register grant, go ARB_LOCK. No beat accepted in ARB_IDLE.
- ARB_LOCK: o_req_ready[g] = slot_free, where slot_free = !o_tx_valid | i_tx_ready; other ready bits 0. Accepted beat loads output register (data, strob, last), o_tx_valid=1.
- Accepted beat with i_req_last=1: next state ARB_IDLE, rr_ptr = (g+1) mod NREQ, o_grant cleared.
- Output register: if slot_free and no beat accepted, o_tx_valid falls to 0 next cycle; data/strob/last held (not cleared).
- Requester dropping valid mid-packet: arbiter stays locked, waits indefinitely; no rotation until last.
- Zero-strob beats forwarded unchanged; arbiter never inspects TLP contents.
- NREQ=1: same FSM, rr_ptr constant 0.
- o_busy = (state==ARB_LOCK) | o_tx_valid.

## Timing
- Reset values: state ARB_IDLE, rr_ptr 0, o_tx_valid 0, o_tx_data 0, o_tx_strob 0, o_tx_last 0, o_req_ready 0, o_grant 0, o_busy 0.
- First-beat latency: valid in cycle N (idle) -> grant at N+1, beat accepted N+1 -> o_tx_valid at N+2.
- Steady-state throughput 1 beat/cycle with i_tx_ready=1.
- One idle (arbitration) cycle between consecutive packets, even from same requester.
- Backpressure: with o_tx_valid=1 and i_tx_ready=0, o_tx_* stable and o_req_ready all 0.
- o_req_ready is combinational from i_tx_ready and registered state; no combinational path from i_req_* to o_req_ready.
- Reset mid-packet: all state cleared asynchronously; partial TLP truncated, downstream recovery is the endpoint's responsibility.

## Structure
- Shared pcie_dma_pkg gains: ARB_IDLE/ARB_LOCK state constants, PCIE_TX_BEAT_WIDTH = 73 (reuse RESP_FIFO_WIDTH), and a pcie_tx_arbiter_registers typedef (state, rr_ptr, grant, tx_valid, tx_data, tx_strob, tx_last) with matching reset constant.
- Sub-module: rr_select (combinational, NREQ-wide valid + pointer -> one-hot grant), reusable by other arbiters.

## Test plan
- Single requester 0 sends 3-beat TLP (data 0x1111..,0x2222..,0x3333.., strob 0xFF, last on beat 3), i_tx_ready=1 -> o_tx_valid cycles 2,3,4 after request, o_tx_last only on third beat, o_grant=01 then 00.
- Both requesters valid in same cycle after reset, 2-beat TLPs each -> req0 fully first, one idle cycle, then req1; rr_ptr=0 after both.
- Req0 continuously valid with back-to-back TLPs, req1 valid -> strict alternation 0,1,0,1; no packet interleaving at beat level.
- i_tx_ready held 0 for 5 cycles mid-packet -> o_tx_data/strob/last unchanged, o_req_ready=00, no beat lost or duplicated after release.
- Requester deasserts valid for 3 cycles mid-packet while other requester valid -> grant stays with first, other never readied until first's last beat.
- Assert i_nrst=0 during beat 2 of 4 -> next edge o_tx_valid=0, o_grant=0, state ARB_IDLE; new TLP after release arbitrated from rr_ptr=0.
